// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the 5-stage MIPS pipeline.
//
// Captures the MEM/WB bundle, selects ALU result or loaded data, and drives the
// decode-stage register-file write port. A one-entry bypass holds the last
// committed write for one cycle so decode/execute can forward around the
// register file's read-during-write window.
//
// Optional feature: define WB_RETIRE_COUNT_EN to add the retire_count output,
// a CNT_W-bit count of committed writes (wraps). Undefined: port and counter absent.
//
// Ports:
//   clk, reset            pipeline clock, synchronous active-high reset
//   in_*                  MEM/WB bundle (valid, mem data, ALU result, dest, controls)
//   stall, flush          hold / squash the pipeline register (flush wins)
//   write_register        register-file write index, {1'b0, dest}
//   write_data            register-file write data
//   RegWrite              register-file write strobe
//   load_mode             register-file load width code
//   fwd_valid/reg/data    bypass entry of the last committed write
//   retire_count          committed-write count (WB_RETIRE_COUNT_EN only)
module wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 6
`ifdef WB_RETIRE_COUNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_mem_read_data,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [4:0]        in_dest_reg,
  input  logic              in_RegWrite,
  input  logic              in_MemToReg,
  input  logic [1:0]        in_load_mode,
  input  logic              stall,
  input  logic              flush,
  output logic [REG_W-1:0]  write_register,
  output logic [DATA_W-1:0] write_data,
  output logic              RegWrite,
  output logic [1:0]        load_mode,
  output logic              fwd_valid,
  output logic [4:0]        fwd_reg,
  output logic [DATA_W-1:0] fwd_data
`ifdef WB_RETIRE_COUNT_EN
  , output logic [CNT_W-1:0] retire_count
`endif
);

  // Pipeline register
  logic              valid_q;
  logic [DATA_W-1:0] mem_data_q;
  logic [DATA_W-1:0] alu_q;
  logic [4:0]        dest_q;
  logic              regwrite_q;
  logic              memtoreg_q;
  logic [1:0]        load_mode_q;
  // Set once the held entry has written, so a stalled entry writes only once
  logic              committed_q;

  // Bypass entry
  logic              fwd_valid_q;
  logic [4:0]        fwd_reg_q;
  logic [DATA_W-1:0] fwd_data_q;

  logic              reg_write;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    sel_data  = memtoreg_q ? mem_data_q : alu_q;
    reg_write = valid_q & regwrite_q & (dest_q != 5'd0) & ~committed_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      mem_data_q  <= '0;
      alu_q       <= '0;
      dest_q      <= '0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      load_mode_q <= '0;
      committed_q <= 1'b0;
    end else if (flush) begin
      // Squash only; the data fields are don't-care once valid is low
      valid_q     <= 1'b0;
      committed_q <= 1'b0;
    end else if (!stall) begin
      valid_q     <= in_valid;
      mem_data_q  <= in_mem_read_data;
      alu_q       <= in_alu_result;
      dest_q      <= in_dest_reg;
      regwrite_q  <= in_RegWrite;
      memtoreg_q  <= in_MemToReg;
      load_mode_q <= in_load_mode;
      committed_q <= 1'b0;
    end else if (reg_write) begin
      committed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_valid_q <= 1'b0;
      fwd_reg_q   <= '0;
      fwd_data_q  <= '0;
    end else begin
      // Valid for exactly the cycle after a commit; contents hold otherwise
      fwd_valid_q <= reg_write;
      if (reg_write) begin
        fwd_reg_q  <= dest_q;
        fwd_data_q <= sel_data;
      end
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  logic [CNT_W-1:0] retire_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_q <= '0;
    end else if (reg_write) begin
      retire_q <= retire_q + 1'b1;
    end
  end

  assign retire_count = retire_q;
`endif

  always_comb begin
    write_register = {{(REG_W-5){1'b0}}, dest_q};
    write_data     = sel_data;
    RegWrite       = reg_write;
    load_mode      = load_mode_q;
    fwd_valid      = fwd_valid_q;
    fwd_reg        = fwd_reg_q;
    fwd_data       = fwd_data_q;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the 5-stage MIPS pipeline; the return path into the decode-stage register file.
- Captures the MEM/WB bundle into its pipeline register and selects ALU result vs. memory data (MemToReg).
- Drives the register-file write port: write_register, write_data, RegWrite, load_mode.
- Holds a one-entry bypass of the last committed write so decode/execute can forward around the register-file read-during-write window.

Parameters:
- DATA_W, 32, datapath width
- REG_W, 6, write_register width; bit 5 always driven 0
- CNT_W, 32, retire counter width (only with WB_RETIRE_COUNT_EN)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  MEM/WB bundle valid
- in_mem_read_data  in  32  data loaded from memory
- in_alu_result  in  32  ALU result
- in_dest_reg  in  5  destination register index
- in_RegWrite  in  1  destination write enable
- in_MemToReg  in  1  1 selects memory data, 0 selects ALU result
- in_load_mode  in  2  load width code, passed through unchanged to the register file
- stall  in  1  hold pipeline register contents
- flush  in  1  squash pipeline register contents
- write_register  out  6  register-file write index
- write_data  out  32  register-file write data
- RegWrite  out  1  register-file write strobe
- load_mode  out  2  register-file load width code
- fwd_valid  out  1  bypass entry valid
- fwd_reg  out  5  bypass destination index
- fwd_data  out  32  bypass data
- retire_count  out  CNT_W  committed-write count (WB_RETIRE_COUNT_EN only)

Behaviour:
- Reset (synchronous, active-high): pipeline register, committed flag, bypass entry and all outputs clear to 0.
- Capture: at posedge with no stall and no flush, register in_valid, data, control and dest.
  - Bundle is visible on the outputs in the next cycle (1-cycle latency).
- Flush: at posedge, clear valid and committed. Takes priority over stall when both are asserted.
- Stall: pipeline register holds.
- Data select: write_data = MemToReg ? mem_read_data : alu_result (registered copies).
- write_register = {1'b0, dest_reg}.
- load_mode forwards the registered in_load_mode.
- Commit rule:
  - RegWrite = valid & reg_RegWrite & (dest_reg != 0) & ~committed.
  - committed sets at the posedge after RegWrite is high.
  - committed clears when a new bundle is captured.
  - A stalled entry therefore writes exactly once.
- Register $0:
  - Writes to dest 0 never assert RegWrite.
  - Writes to dest 0 never load the bypass entry.
- Bypass entry:
  - Loads {dest_reg, write_data} at the posedge where RegWrite is high.
  - fwd_valid = 1 for exactly the following cycle, then clears unless reloaded.
  - Back-to-back commits overwrite the entry each cycle.
- Reset mid-stall: all state cleared; the held entry is dropped and never written.
- Register file samples write_register/write_data/RegWrite on its own posedge. Consumer owns ordering; this block guarantees that outputs are stable for the whole RegWrite-high cycle.

Optional Feature:
- Macro: WB_RETIRE_COUNT_EN.
- Defined:
  - retire_count increments by 1 at each posedge where RegWrite is high.
  - Wraps modulo 2^CNT_W.
  - Reset to 0.
- Undefined: retire_count port and counter are absent; no other behaviour changes.

Test Plan:
- Reset with in_valid=1 -> all outputs 0 for the reset cycle and one cycle after.
- Capture ALU op: in_valid=1, alu=32'h0000_1234, dest=8, RegWrite=1, MemToReg=0
  - next cycle: write_register=6'd8, write_data=32'h1234, RegWrite=1
  - following cycle: fwd_valid=1, fwd_reg=8, fwd_data=32'h1234.
- Load: MemToReg=1, mem=32'hDEAD_BEEF, alu=32'h10, load_mode=2'b01, dest=3 -> write_data=32'hDEADBEEF, load_mode=2'b01, RegWrite=1.
- Dest $0: dest=0, RegWrite=1 -> RegWrite stays 0, fwd_valid stays 0, retire_count unchanged.
- Stall 3 cycles on a valid dest=5 write -> RegWrite high for exactly one cycle; retire_count increments by 1 only.
- stall=1 and flush=1 on the same edge while holding a pending entry -> entry dropped, RegWrite=0 next cycle.
- With WB_RETIRE_COUNT_EN and CNT_W=4: 17 committed writes -> retire_count=1.
